// File: rtl/swerv_types.sv
// Shared types for the execution-unit multiplier: opcode enum and per-op decode.
// Latency: n/a (types, constants and a pure decode function only).
// Backpressure: n/a.
package swerv_types;

   // Multiplier opcode as presented on in_op.
   typedef enum logic [2:0] {
      MUL_OP_MUL    = 3'd0,
      MUL_OP_MULH   = 3'd1,
      MUL_OP_MULHSU = 3'd2,
      MUL_OP_MULHU  = 3'd3,
      MUL_OP_MULW   = 3'd4,
      MUL_OP_CLMUL  = 3'd5,
      MUL_OP_CLMULH = 3'd6,
      MUL_OP_CLMULR = 3'd7
   } mul_op_e;

   // Result-select controls, carried down the pipe to the final stage.
   typedef struct packed {
      logic hi;     // take the upper XLEN bits of the product
      logic word;   // take product[31:0], sign-extended
      logic clmul;  // use the carry-less product
      logic rev;    // carry-less "reversed" window [2*XLEN-2:XLEN-1]
   } mul_sel_t;

   // Full decode: operand signedness (used in stage 1 only) plus the select.
   typedef struct packed {
      logic     a_signed;
      logic     b_signed;
      mul_sel_t sel;
   } mul_ctrl_t;

   localparam mul_sel_t SEL_LO  = '{hi: 1'b0, word: 1'b0, clmul: 1'b0, rev: 1'b0};
   localparam mul_sel_t SEL_HI  = '{hi: 1'b1, word: 1'b0, clmul: 1'b0, rev: 1'b0};
   localparam mul_sel_t SEL_W   = '{hi: 1'b0, word: 1'b1, clmul: 1'b0, rev: 1'b0};
   localparam mul_sel_t SEL_CL  = '{hi: 1'b0, word: 1'b0, clmul: 1'b1, rev: 1'b0};
   localparam mul_sel_t SEL_CLH = '{hi: 1'b1, word: 1'b0, clmul: 1'b1, rev: 1'b0};
   localparam mul_sel_t SEL_CLR = '{hi: 1'b0, word: 1'b0, clmul: 1'b1, rev: 1'b1};

   localparam mul_ctrl_t CTRL_MUL    = '{a_signed: 1'b1, b_signed: 1'b1, sel: SEL_LO};
   localparam mul_ctrl_t CTRL_MULH   = '{a_signed: 1'b1, b_signed: 1'b1, sel: SEL_HI};
   localparam mul_ctrl_t CTRL_MULHSU = '{a_signed: 1'b1, b_signed: 1'b0, sel: SEL_HI};
   localparam mul_ctrl_t CTRL_MULHU  = '{a_signed: 1'b0, b_signed: 1'b0, sel: SEL_HI};
   localparam mul_ctrl_t CTRL_MULW   = '{a_signed: 1'b1, b_signed: 1'b1, sel: SEL_W};
   localparam mul_ctrl_t CTRL_CLMUL  = '{a_signed: 1'b0, b_signed: 1'b0, sel: SEL_CL};
   localparam mul_ctrl_t CTRL_CLMULH = '{a_signed: 1'b0, b_signed: 1'b0, sel: SEL_CLH};
   localparam mul_ctrl_t CTRL_CLMULR = '{a_signed: 1'b0, b_signed: 1'b0, sel: SEL_CLR};

   function automatic mul_ctrl_t mul_decode(input mul_op_e op);
      mul_ctrl_t d;
      d = CTRL_MUL;
      case (op)
         MUL_OP_MUL:    d = CTRL_MUL;
         MUL_OP_MULH:   d = CTRL_MULH;
         MUL_OP_MULHSU: d = CTRL_MULHSU;
         MUL_OP_MULHU:  d = CTRL_MULHU;
         MUL_OP_MULW:   d = CTRL_MULW;
         MUL_OP_CLMUL:  d = CTRL_CLMUL;
         MUL_OP_CLMULH: d = CTRL_CLMULH;
         MUL_OP_CLMULR: d = CTRL_CLMULR;
         default:       d = CTRL_MUL;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/exu_clmul.sv
// Carry-less (GF(2) polynomial) product of two XLEN-bit operands.
// Latency: combinational.
// Backpressure: none; the enclosing pipeline stage owns flow control.
// Ports: a, b - operands; p - 2*XLEN-1 bit carry-less product.
module exu_clmul #(
   parameter int XLEN = 64
) (
   input  logic [XLEN-1:0]   a,
   input  logic [XLEN-1:0]   b,
   output logic [2*XLEN-2:0] p
);

   logic [2*XLEN-2:0] a_w;

   assign a_w = {{(XLEN-1){1'b0}}, a};

   // XOR-accumulate a shifted copy of a for every set bit of b.
   always_comb begin
      p = '0;
      for (int i = 0; i < XLEN; i++) begin
         if (b[i]) begin
            p = p ^ (a_w << i);
         end
      end
   end

endmodule

// File: rtl/exu_mul_pipe.sv
// Pipelined integer / carry-less multiplier: stage 1 decodes operands, middle stages hold the product, last stage selects the result.
// Latency: STAGES cycles from acceptance to out_valid; one op per cycle sustained.
// Backpressure: out_valid & ~out_ready freezes every stage; in_ready drops combinationally during a stall or flush.
// Ports: clk/rst_l clock and async active-low reset; flush kills in-flight ops;
//        in_valid/in_ready/in_op/in_a/in_b/in_tag request; out_valid/out_ready/out_result/out_tag response;
//        busy is high while any stage holds a valid op.
module exu_mul_pipe
   import swerv_types::*;
#(
   parameter int XLEN   = 64,
   parameter int STAGES = 3,
   parameter int TAGW   = 5
) (
   input  logic            clk,
   input  logic            rst_l,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [2:0]      in_op,
   input  logic [XLEN-1:0] in_a,
   input  logic [XLEN-1:0] in_b,
   input  logic [TAGW-1:0] in_tag,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_result,
   output logic [TAGW-1:0] out_tag,
   output logic            busy
);

   // Stages between the decode stage and the select stage (0..2).
   localparam int NMID = STAGES - 2;

   // Payload carried from the product computation to the select stage.
   typedef struct packed {
      mul_sel_t          sel;
      logic [2*XLEN-1:0] prod;
      logic [2*XLEN-2:0] clp;
      logic [TAGW-1:0]   tag;
   } mid_t;

   // ---------------------------------------------------------------
   // Flow control
   // ---------------------------------------------------------------
   logic stall;
   logic accept;

   assign stall    = out_valid & ~out_ready;
   assign in_ready = ~stall & ~flush;
   assign accept   = in_valid & in_ready;

   // ---------------------------------------------------------------
   // Stage 1: operand decode
   // ---------------------------------------------------------------
   mul_ctrl_t       in_ctrl;
   logic            s1_vld;
   logic [XLEN:0]   s1_a;
   logic [XLEN:0]   s1_b;
   mul_sel_t        s1_sel;
   logic [TAGW-1:0] s1_tag;

   assign in_ctrl = mul_decode(mul_op_e'(in_op));

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         s1_vld <= 1'b0;
         s1_a   <= '0;
         s1_b   <= '0;
         s1_sel <= '0;
         s1_tag <= '0;
      end else begin
         if (flush) begin
            s1_vld <= 1'b0;
         end else if (!stall) begin
            s1_vld <= accept;
         end
         // accept already implies the pipe is not stalled
         if (accept) begin
            s1_a   <= {in_ctrl.a_signed & in_a[XLEN-1], in_a};
            s1_b   <= {in_ctrl.b_signed & in_b[XLEN-1], in_b};
            s1_sel <= in_ctrl.sel;
            s1_tag <= in_tag;
         end
      end
   end

   // ---------------------------------------------------------------
   // Product: the (XLEN+1)-bit operands are sign-extended to 2*XLEN so
   // a 2*XLEN-wide multiply yields the exact low 2*XLEN product bits
   // for every signedness combination. Registered across the middle
   // stages so synthesis can retime the multiplier into them.
   // ---------------------------------------------------------------
   logic [2*XLEN-1:0] a_sx;
   logic [2*XLEN-1:0] b_sx;
   logic [2*XLEN-1:0] prod_c;
   logic [2*XLEN-2:0] clp_c;
   mid_t              mid_c;

   assign a_sx   = {{(XLEN-1){s1_a[XLEN]}}, s1_a};
   assign b_sx   = {{(XLEN-1){s1_b[XLEN]}}, s1_b};
   assign prod_c = a_sx * b_sx;

   exu_clmul #(
      .XLEN (XLEN)
   ) u_clmul (
      .a (s1_a[XLEN-1:0]),
      .b (s1_b[XLEN-1:0]),
      .p (clp_c)
   );

   assign mid_c = '{sel: s1_sel, prod: prod_c, clp: clp_c, tag: s1_tag};

   // ---------------------------------------------------------------
   // Middle stages
   // ---------------------------------------------------------------
   logic tail_vld;
   mid_t tail_dat;
   logic mid_busy;

   generate
      if (NMID == 0) begin : g_nomid
         assign tail_vld = s1_vld;
         assign tail_dat = mid_c;
         assign mid_busy = 1'b0;
      end else begin : g_mid
         logic [NMID-1:0] vld_q;
         mid_t            dat_q [NMID];
         logic [NMID:0]   vchain;
         mid_t            dchain [NMID+1];

         // Index 0 is the combinational product; index i+1 is register i.
         assign vchain = {vld_q, s1_vld};

         always_comb begin
            dchain[0] = mid_c;
            for (int i = 0; i < NMID; i++) begin
               dchain[i+1] = dat_q[i];
            end
         end

         always_ff @(posedge clk or negedge rst_l) begin
            if (!rst_l) begin
               vld_q <= '0;
               for (int i = 0; i < NMID; i++) begin
                  dat_q[i] <= '0;
               end
            end else begin
               if (flush) begin
                  vld_q <= '0;
               end else if (!stall) begin
                  vld_q <= vchain[NMID-1:0];
               end
               for (int i = 0; i < NMID; i++) begin
                  if (vchain[i] && !stall) begin
                     dat_q[i] <= dchain[i];
                  end
               end
            end
         end

         assign tail_vld = vchain[NMID];
         assign tail_dat = dchain[NMID];
         assign mid_busy = |vld_q;
      end
   endgenerate

   // ---------------------------------------------------------------
   // Final stage: result select
   // ---------------------------------------------------------------
   logic [XLEN-1:0] res_c;

   always_comb begin
      res_c = tail_dat.prod[XLEN-1:0];
      if (tail_dat.sel.clmul) begin
         if (tail_dat.sel.rev) begin
            res_c = tail_dat.clp[2*XLEN-2:XLEN-1];
         end else if (tail_dat.sel.hi) begin
            // the carry-less product has only 2*XLEN-1 bits, so the MSB is zero
            res_c = {1'b0, tail_dat.clp[2*XLEN-2:XLEN]};
         end else begin
            res_c = tail_dat.clp[XLEN-1:0];
         end
      end else if (tail_dat.sel.word) begin
         // identity when XLEN is 32, so MULW degenerates to MUL there
         res_c = XLEN'($signed(tail_dat.prod[31:0]));
      end else if (tail_dat.sel.hi) begin
         res_c = tail_dat.prod[2*XLEN-1:XLEN];
      end
   end

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         out_valid  <= 1'b0;
         out_result <= '0;
         out_tag    <= '0;
      end else begin
         if (flush) begin
            out_valid <= 1'b0;
         end else if (!stall) begin
            out_valid <= tail_vld;
         end
         // result/tag only move when a new op lands, so they hold through a stall
         if (tail_vld && !stall) begin
            out_result <= res_c;
            out_tag    <= tail_dat.tag;
         end
      end
   end

   assign busy = s1_vld | mid_busy | out_valid;

endmodule
